// File: rtl/t1_cosim_pkg.sv
// rtl/t1_cosim_pkg.sv - shared status codes and FSM states for the cosim watchdog
package t1_cosim_pkg;

   typedef enum logic [7:0] {
      ST_RUNNING          = 8'd0,
      ST_TIMEOUT          = 8'd1,
      ST_UNDERFLOW        = 8'd2,
      ST_OVERFLOW         = 8'd3,
      ST_ISSUE_AFTER_QUIT = 8'd4,
      ST_DONE             = 8'd255
   } status_e;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE,
      S_ERROR
   } state_e;

endpackage

// File: rtl/cosim_sat_counter.sv
// rtl/cosim_sat_counter.sv - saturating up/down counter with underflow/overflow flags
module cosim_sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         underflow,
   output logic         overflow
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // Flags are raw attempts to step past a rail; the count itself never wraps.
   always_comb begin
      underflow = dec & ~inc & (count == '0);
      overflow  = inc & ~dec & (count == '1);
      count_nxt = count;
      if (inc & ~dec & ~overflow)
         count_nxt = count + ONE;
      else if (dec & ~inc & ~underflow)
         count_nxt = count - ONE;
   end

   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (en)
         count <= count_nxt;
   end

endmodule

// File: rtl/cosim_watchdog.sv
// rtl/cosim_watchdog.sv - co-simulation progress watchdog; T1_WATCHDOG_CYCLE_COUNT_EN enables cycle accounting
module cosim_watchdog
   import t1_cosim_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int OUTSTANDING_W  = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic                     retire_valid,
   input  logic                     quit_req,
   output logic [7:0]               status,
   output logic [OUTSTANDING_W-1:0] outstanding,
   output logic [63:0]              cycle_count,
   output logic [63:0]              status_cycle
);

   localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

   state_e              state, state_nxt;
   status_e             status_q, status_nxt, err_code;
   logic [IDLE_W-1:0]   idle;
   logic [OUTSTANDING_W-1:0] out_nxt;
   logic                underflow, overflow, err, active, progress, timeout, nxt_zero, term;

   assign active   = (state == S_RUN) || (state == S_DRAIN);
   assign progress = issue_valid | retire_valid;
   assign timeout  = ~progress && (idle == IDLE_LAST);
   assign nxt_zero = (out_nxt == '0);
   assign term     = active && ((state_nxt == S_DONE) || (state_nxt == S_ERROR));
   assign status   = status_q;

   // The faulting event is not counted, so outstanding freezes at its pre-error value.
   cosim_sat_counter #(.W(OUTSTANDING_W)) u_outstanding (
      .clock     (clock),
      .reset     (reset),
      .en        (active & ~err),
      .inc       (issue_valid),
      .dec       (retire_valid),
      .count     (outstanding),
      .count_nxt (out_nxt),
      .underflow (underflow),
      .overflow  (overflow)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_RUN;
         status_q <= ST_RUNNING;
         idle     <= '0;
      end else begin
         state    <= state_nxt;
         status_q <= status_nxt;
         if (active)
            idle <= progress ? '0 : idle + IDLE_ONE;
      end
   end

   always_comb begin
      err        = 1'b0;
      err_code   = ST_RUNNING;
      state_nxt  = state;
      status_nxt = status_q;
      if (active) begin
         if (underflow) begin
            err = 1'b1; err_code = ST_UNDERFLOW;
         end else if (overflow) begin
            err = 1'b1; err_code = ST_OVERFLOW;
         end else if ((state == S_DRAIN) && issue_valid) begin
            err = 1'b1; err_code = ST_ISSUE_AFTER_QUIT;
         end else if (timeout) begin
            err = 1'b1; err_code = ST_TIMEOUT;
         end

         if (err) begin
            state_nxt  = S_ERROR;
            status_nxt = err_code;
         end else if (state == S_RUN) begin
            if (quit_req) begin
               if (!issue_valid && nxt_zero) begin
                  state_nxt  = S_DONE;
                  status_nxt = ST_DONE;
               end else begin
                  state_nxt = S_DRAIN;
               end
            end
         end else if (nxt_zero) begin
            state_nxt  = S_DONE;
            status_nxt = ST_DONE;
         end
      end
   end

`ifdef T1_WATCHDOG_CYCLE_COUNT_EN
   logic [63:0] cyc_q, stat_cyc_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q      <= '0;
         stat_cyc_q <= '0;
      end else begin
         cyc_q <= cyc_q + 64'd1;
         if (term)
            stat_cyc_q <= cyc_q;
      end
   end

   assign cycle_count  = cyc_q;
   assign status_cycle = stat_cyc_q;
`else
   logic unused_term;
   assign unused_term  = term;
   assign cycle_count  = '0;
   assign status_cycle = '0;
`endif

endmodule

// File: tb/tb_cosim_watchdog.sv
// tb/tb_cosim_watchdog.sv - directed scoreboard bench for cosim_watchdog
module tb_cosim_watchdog;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0;
   logic        retire_valid = 1'b0;
   logic        quit_req = 1'b0;
   logic [7:0]  status;
   logic [3:0]  outstanding;
   logic [63:0] cycle_count;
   logic [63:0] status_cycle;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [7:0] st;
      logic [3:0] out;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   cosim_watchdog #(.TIMEOUT_CYCLES(16), .OUTSTANDING_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .retire_valid (retire_valid),
      .quit_req     (quit_req),
      .status       (status),
      .outstanding  (outstanding),
      .cycle_count  (cycle_count),
      .status_cycle (status_cycle)
   );

   task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         n_checks++;
         assert (status === e.st) else begin
            n_fail++;
            $error("FAIL %s_status observed=%0d expected=%0d", e.tag, status, e.st);
         end
         n_checks++;
         assert (outstanding === e.out) else begin
            n_fail++;
            $error("FAIL %s_outstanding observed=%0d expected=%0d", e.tag, outstanding, e.out);
         end
      end
   endtask

   // Drive one cycle; expectation is queued with the stimulus and compared once the edge has passed.
   task automatic step(input logic i, input logic r, input logic q,
                       input string tag, input logic [7:0] st, input logic [3:0] o);
      exp_t e;
      e.tag = tag; e.st = st; e.out = o;
      sb.push_back(e);
      issue_valid = i; retire_valid = r; quit_req = q;
      @(posedge clock);
      #1;
      issue_valid = 1'b0; retire_valid = 1'b0; quit_req = 1'b0;
      compare_front();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset(input string tag);
      exp_t e;
      e.tag = tag; e.st = 8'd0; e.out = 4'd0;
      sb.push_back(e);
      reset = 1'b1;
      issue_valid = 1'b1; retire_valid = 1'b0; quit_req = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      issue_valid = 1'b0; quit_req = 1'b0;
      compare_front();
   endtask

   initial begin
      #1;
      idle(1);
      do_reset("reset_init");
      check64("reset_cycle_count", cycle_count, 64'd0);
      check64("reset_status_cycle", status_cycle, 64'd0);

      // three issues, three retires, then quit
      step(1, 0, 0, "a_issue1", 8'd0, 4'd1);
      step(1, 0, 0, "a_issue2", 8'd0, 4'd2);
      step(1, 0, 0, "a_issue3", 8'd0, 4'd3);
      step(1, 1, 0, "a_both",   8'd0, 4'd3);
      step(0, 1, 0, "a_ret1",   8'd0, 4'd2);
      step(0, 1, 0, "a_ret2",   8'd0, 4'd1);
      step(0, 1, 0, "a_ret3",   8'd0, 4'd0);
      step(0, 0, 1, "a_quit",   8'd255, 4'd0);
      step(1, 0, 0, "a_sticky", 8'd255, 4'd0);

      do_reset("b_reset");
      step(1, 0, 0, "b_issue1", 8'd0, 4'd1);
      step(1, 0, 0, "b_issue2", 8'd0, 4'd2);
      step(0, 0, 1, "b_quit",   8'd0, 4'd2);
      step(0, 1, 0, "b_ret1",   8'd0, 4'd1);
      step(0, 1, 0, "b_ret2",   8'd255, 4'd0);

      do_reset("c_reset");
      step(1, 0, 0, "c_issue", 8'd0, 4'd1);
      idle(14);
      step(0, 0, 0, "c_idle15", 8'd0, 4'd1);
      step(0, 0, 0, "c_idle16", 8'd1, 4'd1);
      step(0, 0, 1, "c_quit_after", 8'd1, 4'd1);

      do_reset("d_reset");
      idle(15);
      step(0, 1, 0, "d_underflow", 8'd2, 4'd0);

      do_reset("e_reset");
      for (int k = 1; k <= 15; k++)
         step(1, 0, 0, $sformatf("e_issue%0d", k), 8'd0, 4'(k));
      step(1, 0, 0, "e_overflow", 8'd3, 4'd15);
      step(0, 1, 0, "e_frozen",   8'd3, 4'd15);

      do_reset("f_reset");
      step(1, 0, 0, "f_issue", 8'd0, 4'd1);
      step(0, 0, 1, "f_quit",  8'd0, 4'd1);
      step(1, 0, 0, "f_iaq",   8'd4, 4'd1);
`ifdef T1_WATCHDOG_CYCLE_COUNT_EN
      check64("f_status_cycle", status_cycle, 64'd2);
      check64("f_cycle_count", cycle_count, 64'd3);
`else
      check64("f_status_cycle", status_cycle, 64'd0);
      check64("f_cycle_count", cycle_count, 64'd0);
`endif
      do_reset("f_reset2");
      check64("f_cycle_restart", cycle_count, 64'd0);
      step(0, 0, 0, "f_after", 8'd0, 4'd0);
`ifdef T1_WATCHDOG_CYCLE_COUNT_EN
      check64("f_cycle_one", cycle_count, 64'd1);
`else
      check64("f_cycle_one", cycle_count, 64'd0);
`endif
      check64("f_status_cycle_clr", status_cycle, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cosim_watchdog.md
COSIM_WATCHDOG -- requirements
Module: cosim_watchdog

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: cycles without progress before timeout (min 2).
REQ-002 SHALL have parameter OUTSTANDING_W, default 8: width of the outstanding-instruction counter.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port issue_valid, input, 1 bit: one instruction issued this cycle.
REQ-006 SHALL have port retire_valid, input, 1 bit: one instruction retired this cycle.
REQ-007 SHALL have port quit_req, input, 1 bit: testbench-side finish request, sampled each cycle.
REQ-008 SHALL have port status, output, 8 bits: 0 = running, 255 = done, 1 = timeout, 2 = underflow, 3 = overflow, 4 = issue-after-quit.
REQ-009 SHALL have port outstanding, output, OUTSTANDING_W bits: current in-flight count.
REQ-010 SHALL have port cycle_count, output, 64 bits: cycles since reset release (see Configuration).
REQ-011 SHALL have port status_cycle, output, 64 bits: cycle_count value latched at the terminal transition.

Function
REQ-012 SHALL implement FSM states RUN, DRAIN, DONE, ERROR; status is registered and changes the cycle after the causing event.
REQ-013 SHALL update outstanding: +1 on issue only, -1 on retire only, unchanged on both or neither.
REQ-014 SHALL flag underflow (code 2) on retire-only with outstanding == 0; counter does not wrap.
REQ-015 SHALL flag overflow (code 3) on issue-only with outstanding == all-ones; counter does not wrap.
REQ-016 SHALL hold idle counter at 0 on any issue_valid or retire_valid, else increment, in RUN and DRAIN.
REQ-017 SHALL flag timeout (code 1) when idle counter equals TIMEOUT_CYCLES-1 and no progress occurs that cycle.
REQ-018 SHALL go RUN->DONE when quit_req is high, issue_valid is low and the post-update outstanding is 0; otherwise quit_req moves RUN->DRAIN.
REQ-019 SHALL go DRAIN->DONE when the post-update outstanding reaches 0; quit_req is ignored once in DRAIN.
REQ-020 SHALL flag issue-after-quit (code 4) on issue_valid in DRAIN.
REQ-021 SHALL apply error priority underflow > overflow > issue-after-quit > timeout; any error beats the DONE transition in the same cycle.
REQ-022 SHALL keep DONE and ERROR sticky until reset; inputs are ignored there and outstanding is frozen.
REQ-023 SHALL latch status_cycle exactly once, on entry to DONE or ERROR.

Reset
REQ-024 SHALL drive reset values: state RUN, status 0, outstanding 0, idle counter 0, cycle_count 0, status_cycle 0.
REQ-025 SHALL abort any state on reset asserted mid-operation, with no residual error.
REQ-026 SHALL ignore all inputs while reset is high.

Configuration
REQ-027 SHALL gate cycle accounting with macro T1_WATCHDOG_CYCLE_COUNT_EN.
REQ-028 SHALL, with the macro defined: cycle_count increments every non-reset cycle, and status_cycle latches per REQ-023.
REQ-029 SHALL, without the macro: cycle_count and status_cycle are constant 0, no 64-bit registers are synthesized, and FSM behaviour is unchanged.

Structure
REQ-030 SHALL place the status-code typedef (8-bit enum, values per REQ-008) and FSM state enum in shared package t1_cosim_pkg.
REQ-031 SHALL instantiate sub-module cosim_sat_counter (parameterized width, inc/dec, saturation flags) for outstanding.

Verification
REQ-032 Verification SHALL use TIMEOUT_CYCLES=16 and OUTSTANDING_W=4 for all scenarios below.
REQ-033 3 issues, 3 retires, then quit_req -> status 255 one cycle after quit, outstanding 0.
REQ-034 2 issues, quit_req, 1 retire, 1 retire -> DRAIN, then status 255 the cycle after the 2nd retire.
REQ-035 1 issue, then 16 idle cycles -> status 1 after the 16th idle cycle; quit_req afterwards keeps status 1.
REQ-036 Retire at outstanding 0 together with idle timeout in the same cycle -> status 2 (priority).
REQ-037 16 issues-only -> status 3 on the 16th; outstanding stays 15.
REQ-038 Issue during DRAIN -> status 4; then reset for 1 cycle -> status 0, outstanding 0; with macro, cycle_count restarts at 0.
